hazard_ctrl: RTL and testbench

Pipeline hazard controller for the three-stage Riscv151 core: decode-read (D), execute (X), writeback (W). It keeps a two-entry scoreboard of in-flight register writers and handles three kinds of hazard:
- RAW hazards, resolved by forwarding into the decode-read operand path;
- load-use hazards, resolved by a one-cycle interlock;
- control redirects resolved in X, resolved by squashing wrong-path instructions.

It drives the core's `bubble` input to the decode stage, plus a fetch-hold and operand-forward selects. It honours the memory-system `stall` by freezing its state.

---
 rtl/hazard_ctrl.sv | 115 +++++++++++
 tb/tb_hazard_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: two-slot scoreboard hazard controller for the three-stage Riscv151 pipeline.
// Define HAZARD_FWD_EN to forward from X/W; without it every RAW dependency interlocks.
module hazard_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       stall,
  input  logic       dec_valid,
  input  logic [4:0] dec_rs1,
  input  logic [4:0] dec_rs2,
  input  logic       dec_uses_rs1,
  input  logic       dec_uses_rs2,
  input  logic [4:0] dec_rd,
  input  logic       dec_reg_we,
  input  logic       dec_is_load,
  input  logic       ex_redirect,
  output logic       bubble,
  output logic       pc_hold,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t     state_q, state_d;

  logic       exValid_q;
  logic [4:0] exRd_q;
  logic       exWe_q;
  logic       exLoad_q;

  // The W slot never needs its load flag: a W-stage load result is always forwardable.
  logic       wbValid_q;
  logic [4:0] wbRd_q;
  logic       wbWe_q;

  logic       exWriter, wbWriter;
  logic       matchExA, matchExB, matchWbA, matchWbB;
  logic       interlock;

  always_comb begin
    exWriter = exValid_q & exWe_q & (exRd_q != 5'd0);
    wbWriter = wbValid_q & wbWe_q & (wbRd_q != 5'd0);

    matchExA = dec_uses_rs1 & exWriter & (exRd_q == dec_rs1);
    matchExB = dec_uses_rs2 & exWriter & (exRd_q == dec_rs2);
    matchWbA = dec_uses_rs1 & wbWriter & (wbRd_q == dec_rs1);
    matchWbB = dec_uses_rs2 & wbWriter & (wbRd_q == dec_rs2);

`ifdef HAZARD_FWD_EN
    interlock = exLoad_q & (matchExA | matchExB);
`else
    interlock = matchExA | matchExB | matchWbA | matchWbB;
`endif

    bubble    = 1'b0;
    pc_hold   = 1'b0;
    fwd_a_sel = 2'd0;
    fwd_b_sel = 2'd0;
    state_d   = state_q;

    // A redirect outranks a pending interlock: the stalled instruction is wrong-path anyway.
    case (state_q)
      RUN: begin
        if (ex_redirect) begin
          bubble  = 1'b1;
          state_d = FLUSH;
        end else if (interlock) begin
          bubble  = 1'b1;
          pc_hold = 1'b1;
        end
      end
      FLUSH: begin
        bubble  = 1'b1;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase

`ifdef HAZARD_FWD_EN
    if (!bubble) begin
      fwd_a_sel = matchExA ? 2'd1 : (matchWbA ? 2'd2 : 2'd0);
      fwd_b_sel = matchExB ? 2'd1 : (matchWbB ? 2'd2 : 2'd0);
    end
`endif
  end

`ifndef HAZARD_FWD_EN
  logic unusedExLoad;
  assign unusedExLoad = exLoad_q;
`endif

  // Scoreboard shifts X into W each unstalled edge; bubbled D instructions enter X as invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      exValid_q <= 1'b0;
      exRd_q    <= 5'd0;
      exWe_q    <= 1'b0;
      exLoad_q  <= 1'b0;
      wbValid_q <= 1'b0;
      wbRd_q    <= 5'd0;
      wbWe_q    <= 1'b0;
    end else if (!stall) begin
      state_q   <= state_d;
      wbValid_q <= exValid_q;
      wbRd_q    <= exRd_q;
      wbWe_q    <= exWe_q;
      exValid_q <= dec_valid & ~bubble;
      exRd_q    <= dec_rd;
      exWe_q    <= dec_reg_we;
      exLoad_q  <= dec_is_load;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed plus random checks of hazard_ctrl against a behavioural pipeline model.
// Honours HAZARD_FWD_EN the same way the design does.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset, stall, dec_valid;
  logic [4:0] dec_rs1, dec_rs2, dec_rd;
  logic       dec_uses_rs1, dec_uses_rs2, dec_reg_we, dec_is_load, ex_redirect;
  logic       bubble, pc_hold;
  logic [1:0] fwd_a_sel, fwd_b_sel;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall), .dec_valid(dec_valid),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_uses_rs1(dec_uses_rs1), .dec_uses_rs2(dec_uses_rs2),
    .dec_rd(dec_rd), .dec_reg_we(dec_reg_we), .dec_is_load(dec_is_load),
    .ex_redirect(ex_redirect), .bubble(bubble), .pc_hold(pc_hold),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
  );

  int checks = 0;
  int errors = 0;

  // Instructions in flight: index 0 is the one in X, index 1 the one in W.
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       we;
    logic       ld;
  } instr_t;

  instr_t     pipe [2];
  bit         flushPending;
  logic       expBubble, expHold;
  logic [1:0] expSelA, expSelB;

  // Age of the youngest in-flight instruction producing rs (1 = X, 2 = W), or 0.
  function automatic int producerAge(logic uses, logic [4:0] rs);
    if (!uses || rs == 5'd0) return 0;
    for (int age = 0; age < 2; age++)
      if (pipe[age].v && pipe[age].we && pipe[age].rd == rs) return age + 1;
    return 0;
  endfunction

  task automatic modelOutputs();
    int  ageA, ageB;
    bit  stallNeeded;
    ageA = producerAge(dec_uses_rs1, dec_rs1);
    ageB = producerAge(dec_uses_rs2, dec_rs2);
`ifdef HAZARD_FWD_EN
    stallNeeded = pipe[0].ld && (ageA == 1 || ageB == 1);
`else
    stallNeeded = (ageA != 0) || (ageB != 0);
`endif
    expBubble = 1'b0;
    expHold   = 1'b0;
    if (flushPending || ex_redirect) expBubble = 1'b1;
    else if (stallNeeded) begin
      expBubble = 1'b1;
      expHold   = 1'b1;
    end
    expSelA = 2'd0;
    expSelB = 2'd0;
`ifdef HAZARD_FWD_EN
    if (!expBubble) begin
      expSelA = 2'(ageA);
      expSelB = 2'(ageB);
    end
`endif
  endtask

  task automatic compare(string tag, logic [1:0] obs, logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(string tag);
    #1;
    modelOutputs();
    compare({tag, ".bubble"}, {1'b0, bubble}, {1'b0, expBubble});
    compare({tag, ".pc_hold"}, {1'b0, pc_hold}, {1'b0, expHold});
    compare({tag, ".fwd_a"}, fwd_a_sel, expSelA);
    compare({tag, ".fwd_b"}, fwd_b_sel, expSelB);
  endtask

  task automatic clockEdge();
    @(posedge clk);
    if (reset) begin
      pipe[0]      = '0;
      pipe[1]      = '0;
      flushPending = 1'b0;
    end else if (!stall) begin
      pipe[1]      = pipe[0];
      pipe[0]      = '{v: dec_valid & ~expBubble, rd: dec_rd, we: dec_reg_we, ld: dec_is_load};
      flushPending = !flushPending && ex_redirect;
    end
    @(negedge clk);
  endtask

  task automatic applyStimulus(logic v, logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                               logic [4:0] rd, logic we, logic ld);
    dec_valid = v; dec_rs1 = rs1; dec_uses_rs1 = u1; dec_rs2 = rs2; dec_uses_rs2 = u2;
    dec_rd = rd; dec_reg_we = we; dec_is_load = ld;
  endtask

  // Re-present the current D instruction while the model says the PC is held (bounded).
  task automatic presentUntilAccepted(string tag);
    for (int i = 0; i < 4; i++) begin
      checkOutput(tag);
      clockEdge();
      if (!expHold) return;
    end
    checks++;
    errors++;
    $error("[TB] FAIL %s.hold_bound: observed held expected released", tag);
  endtask

  initial begin
    pipe[0] = '0; pipe[1] = '0; flushPending = 1'b0;
    reset = 1'b1; stall = 1'b0; ex_redirect = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    clockEdge();
    reset = 1'b0;

    // Reset state: quiet inputs give all-zero outputs
    checkOutput("reset");
    compare("reset_bubble", {1'b0, bubble}, 2'd0);
    compare("reset_sel_a", fwd_a_sel, 2'd0);
    clockEdge();

    // addi x5 then add x6,x5,x5
    applyStimulus(1, 0, 1, 0, 0, 5, 1, 0);
    checkOutput("addi");
    clockEdge();
    applyStimulus(1, 5, 1, 5, 1, 6, 1, 0);
    presentUntilAccepted("add_dep");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("drain1"); clockEdge();
    checkOutput("drain2"); clockEdge();

    // lw x7 then sub x8,x7,x1
    applyStimulus(1, 2, 1, 0, 0, 7, 1, 1);
    checkOutput("lw");
    clockEdge();
    applyStimulus(1, 7, 1, 1, 1, 8, 1, 0);
    presentUntilAccepted("load_use");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("drain3"); clockEdge();
    checkOutput("drain4"); clockEdge();

    // Single-cycle redirect: exactly two bubbles, no PC hold
    applyStimulus(1, 0, 0, 0, 0, 10, 1, 0);
    ex_redirect = 1'b1;
    checkOutput("redir0");
    compare("redir0_bubble", {1'b0, bubble}, 2'd1);
    compare("redir0_hold", {1'b0, pc_hold}, 2'd0);
    clockEdge();
    ex_redirect = 1'b0;
    applyStimulus(1, 0, 0, 0, 0, 11, 1, 0);
    checkOutput("redir1");
    compare("redir1_bubble", {1'b0, bubble}, 2'd1);
    clockEdge();
    applyStimulus(1, 10, 1, 11, 1, 12, 0, 0);
    checkOutput("redir2");
    compare("redir2_bubble", {1'b0, bubble}, 2'd0);
    compare("redir2_sel_b", fwd_b_sel, 2'd0);
    clockEdge();

    // Redirect coinciding with load-use, then stall inside FLUSH
    applyStimulus(1, 3, 1, 0, 0, 13, 1, 1);
    checkOutput("lw13"); clockEdge();
    applyStimulus(1, 13, 1, 0, 0, 14, 1, 0);
    ex_redirect = 1'b1;
    checkOutput("redir_lu");
    compare("redir_lu_hold", {1'b0, pc_hold}, 2'd0);
    compare("redir_lu_bubble", {1'b0, bubble}, 2'd1);
    clockEdge();
    ex_redirect = 1'b1;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("flush_stall");
      compare("flush_stall_bubble", {1'b0, bubble}, 2'd1);
      clockEdge();
    end
    stall = 1'b0;
    checkOutput("flush_unstalled");
    compare("flush_unstalled_bubble", {1'b0, bubble}, 2'd1);
    clockEdge();
    ex_redirect = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("after_flush");
    compare("after_flush_bubble", {1'b0, bubble}, 2'd0);
    clockEdge();

    // x0 writer then x0 reader
    applyStimulus(1, 1, 1, 0, 0, 0, 1, 1);
    checkOutput("x0_wr"); clockEdge();
    applyStimulus(1, 0, 1, 0, 1, 15, 1, 0);
    checkOutput("x0_rd");
    compare("x0_rd_bubble", {1'b0, bubble}, 2'd0);
    compare("x0_rd_sel_a", fwd_a_sel, 2'd0);
    clockEdge();

    // Two writers to x9, then a reader
    applyStimulus(1, 0, 0, 0, 0, 9, 1, 0);
    checkOutput("x9_a"); clockEdge();
    checkOutput("x9_b"); clockEdge();
    applyStimulus(1, 9, 1, 9, 1, 16, 1, 0);
    presentUntilAccepted("x9_rd");

    // Reset while in FLUSH with stall asserted
    applyStimulus(1, 0, 0, 0, 0, 17, 1, 1);
    ex_redirect = 1'b1;
    checkOutput("pre_rst"); clockEdge();
    ex_redirect = 1'b0;
    stall = 1'b1;
    reset = 1'b1;
    clockEdge();
    reset = 1'b0;
    stall = 1'b0;
    applyStimulus(1, 17, 1, 17, 1, 18, 1, 0);
    checkOutput("rst_flush");
    compare("rst_flush_bubble", {1'b0, bubble}, 2'd0);
    compare("rst_flush_hold", {1'b0, pc_hold}, 2'd0);
    compare("rst_flush_sel_a", fwd_a_sel, 2'd0);
    compare("rst_flush_sel_b", fwd_b_sel, 2'd0);
    clockEdge();

    // Random traffic over a small register set to provoke frequent dependencies
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 7) != 0), 5'($urandom_range(0, 3)), 1'($urandom),
                    5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
                    1'($urandom), ($urandom_range(0, 2) == 0));
      ex_redirect = ($urandom_range(0, 7) == 0);
      stall       = ($urandom_range(0, 5) == 0);
      reset       = ($urandom_range(0, 49) == 0);
      checkOutput("random");
      clockEdge();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
